// File: rtl/ps2_host_tx_if.sv
// Byte handshake between a command source and the PS/2 host transmitter.
// master drives the byte and strobe; slave reports ready and the terminal pulses.
interface ps2_host_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       tx_done;
    logic       tx_err;

    modport master (output tx_data, output tx_valid,
                    input  tx_ready, input tx_done, input tx_err);
    modport slave  (input  tx_data, input tx_valid,
                    output tx_ready, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, 11-bit frame, ACK check.
// Define PS2_HOST_TX_FILTER_EN to require 8-cycle stable high/low around each clock fall.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 2500,
    parameter int TIMEOUT_CYCLES = 375000
) (
    input  logic         clk25,
    input  logic         rst_n,
    ps2_host_tx_if.slave tx,
    input  logic         ps2_clk,
    input  logic         ps2_din,
    output logic         ps2_clk_oe,
    output logic         ps2_din_oe
);
    localparam int MAX_CYCLES = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, BITS, ACK, WAITIDLE} state_t;

    logic [1:0] clk_sync_reg;
    logic [1:0] din_sync_reg;
    logic       clk_s;
    logic       din_s;
    logic       fall;

    // Idle PS/2 lines are pulled high, so the synchronizers reset to 1.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_reg <= 2'b11;
            din_sync_reg <= 2'b11;
        end else begin
            clk_sync_reg <= {clk_sync_reg[0], ps2_clk};
            din_sync_reg <= {din_sync_reg[0], ps2_din};
        end
    end

    assign clk_s = clk_sync_reg[1];
    assign din_s = din_sync_reg[1];

`ifdef PS2_HOST_TX_FILTER_EN
    logic [3:0] hi_cnt_reg;
    logic [3:0] lo_cnt_reg;
    logic       armed_reg;

    // armed survives short low glitches; only a full 8-cycle low after arming counts.
    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            hi_cnt_reg <= 4'd0;
            lo_cnt_reg <= 4'd0;
            armed_reg  <= 1'b0;
        end else if (clk_s) begin
            lo_cnt_reg <= 4'd0;
            if (hi_cnt_reg != 4'd8) hi_cnt_reg <= hi_cnt_reg + 4'd1;
            if (hi_cnt_reg == 4'd7) armed_reg <= 1'b1;
        end else begin
            hi_cnt_reg <= 4'd0;
            if (lo_cnt_reg != 4'd8) lo_cnt_reg <= lo_cnt_reg + 4'd1;
            if (fall) armed_reg <= 1'b0;
        end
    end

    assign fall = !clk_s && (lo_cnt_reg == 4'd7) && armed_reg;
`else
    logic clk_prev_reg;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) clk_prev_reg <= 1'b1;
        else        clk_prev_reg <= clk_s;
    end

    assign fall = clk_prev_reg && !clk_s;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [3:0]       bit_idx_reg, bit_idx_next;
    logic [8:0]       frame_reg, frame_next;
    logic             bit_oe_reg, bit_oe_next;
    logic             nack_reg, nack_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             ready_int;

    always_ff @(posedge clk25 or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= 4'd0;
            frame_reg   <= 9'd0;
            bit_oe_reg  <= 1'b0;
            nack_reg    <= 1'b0;
            done_reg    <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            frame_reg   <= frame_next;
            bit_oe_reg  <= bit_oe_next;
            nack_reg    <= nack_next;
            done_reg    <= done_next;
            err_reg     <= err_next;
        end
    end

    // A pending terminal pulse blocks acceptance so the two never share a cycle.
    assign ready_int = (state_reg == IDLE) && !done_reg && !err_reg;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        frame_next   = frame_reg;
        bit_oe_next  = bit_oe_reg;
        nack_next    = nack_reg;
        done_next    = 1'b0;
        err_next     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (tx.tx_valid && ready_int) begin
                    frame_next = {~^tx.tx_data, tx.tx_data};
                    cnt_next   = '0;
                    state_next = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_reg == INHIBIT_LAST) begin
                    cnt_next   = '0;
                    state_next = REQ;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            REQ, BITS, ACK, WAITIDLE: begin
                cnt_next = fall ? '0 : cnt_reg + CNT_W'(1);
                case (state_reg)
                    REQ: if (fall) begin
                        bit_idx_next = 4'd0;
                        bit_oe_next  = ~frame_reg[0];
                        state_next   = BITS;
                    end
                    BITS: if (fall) begin
                        if (bit_idx_reg == 4'd8) begin
                            bit_oe_next = 1'b0;
                            state_next  = ACK;
                        end else begin
                            bit_idx_next = bit_idx_reg + 4'd1;
                            bit_oe_next  = ~frame_reg[bit_idx_reg + 4'd1];
                        end
                    end
                    ACK: if (fall) begin
                        nack_next  = din_s;
                        state_next = WAITIDLE;
                    end
                    default: if (clk_s && din_s) begin
                        done_next  = ~nack_reg;
                        err_next   = nack_reg;
                        state_next = IDLE;
                    end
                endcase
                if (!fall && cnt_reg == TIMEOUT_LAST) begin
                    bit_oe_next = 1'b0;
                    done_next   = 1'b0;
                    err_next    = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Line drives decode straight from state so reset releases them immediately.
    assign ps2_clk_oe = (state_reg == INHIBIT);
    assign ps2_din_oe = ((state_reg == INHIBIT) && (cnt_reg == INHIBIT_LAST)) ||
                        (state_reg == REQ) ||
                        ((state_reg == BITS) && bit_oe_reg);

    assign tx.tx_ready = ready_int;
    assign tx.tx_done  = done_reg;
    assign tx.tx_err   = err_reg;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Self-checking bench for ps2_host_tx with an open-drain PS/2 device model.
// Expected frames are queued at send time and popped when the device has clocked them out.
`timescale 1ns/1ps
module tb_ps2_host_tx;
    localparam int INH  = 50;
    localparam int TMO  = 600;
    localparam int HALF = 20;
`ifdef PS2_HOST_TX_FILTER_EN
    localparam bit GLITCH = 1'b1;
`else
    localparam bit GLITCH = 1'b0;
`endif

    logic clk25 = 1'b0;
    logic rst_n = 1'b0;
    logic dev_clk = 1'b1;
    logic dev_din = 1'b1;
    logic ps2_clk_line, ps2_din_line, ps2_clk_oe, ps2_din_oe;

    ps2_host_tx_if txi();

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk25      (clk25),
        .rst_n      (rst_n),
        .tx         (txi.slave),
        .ps2_clk    (ps2_clk_line),
        .ps2_din    (ps2_din_line),
        .ps2_clk_oe (ps2_clk_oe),
        .ps2_din_oe (ps2_din_oe)
    );

    assign ps2_clk_line = dev_clk & ~ps2_clk_oe;
    assign ps2_din_line = dev_din & ~ps2_din_oe;

    always #20 clk25 = ~clk25;

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0, both_cnt = 0;
    logic [10:0] exp_q[$];

    always begin
        @(posedge clk25);
        #1;
        if (txi.tx_done === 1'b1) done_cnt++;
        if (txi.tx_err === 1'b1) err_cnt++;
        if (txi.tx_done === 1'b1 && txi.tx_err === 1'b1) both_cnt++;
    end

    initial begin
        #10ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b, input bit hold);
        int w = 0;
        int ones = 0;
        logic par;
        while (txi.tx_ready !== 1'b1 && w < 200) begin @(negedge clk25); w++; end
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0);
        exp_q.push_back({1'b1, par, b, 1'b0});
        txi.tx_data  = b;
        txi.tx_valid = 1'b1;
        @(negedge clk25);
        if (!hold) txi.tx_valid = 1'b0;
        n_cmp++;
        if (txi.tx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL accept_ready: tx_ready=%b required 0", txi.tx_ready);
        end
    endtask

    task automatic dev_run(input int n_fall, input bit nack, input bit glitch,
                           output logic [10:0] bits, output int inh_len, output logic last_oe);
        bits = '1;
        inh_len = 0;
        last_oe = 1'b0;
        while (ps2_clk_oe === 1'b1 && inh_len < 4 * INH) begin
            last_oe = ps2_din_oe;
            inh_len++;
            @(negedge clk25);
        end
        if (n_fall > 0) begin
            repeat (HALF) @(negedge clk25);
            bits[0] = ps2_din_line;
            for (int k = 1; k <= n_fall; k++) begin
                if (k == 11) dev_din = nack;
                dev_clk = 1'b0;
                repeat (HALF) @(negedge clk25);
                dev_clk = 1'b1;
                repeat (HALF / 2) @(negedge clk25);
                if (k <= 10) bits[k] = ps2_din_line;
                if (glitch && k == 5) begin
                    dev_clk = 1'b0;
                    repeat (2) @(negedge clk25);
                    dev_clk = 1'b1;
                    repeat (HALF) @(negedge clk25);
                end
                repeat (HALF - HALF / 2) @(negedge clk25);
                dev_din = 1'b1;
            end
        end
    endtask

    task automatic wait_pulse(input int d0, input int e0, output int cyc);
        cyc = 0;
        while (done_cnt == d0 && err_cnt == e0 && cyc < 300) begin
            @(negedge clk25);
            cyc++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        txi.tx_valid = 1'b0;
        txi.tx_data  = 8'h00;
        repeat (3) @(negedge clk25);
        n_cmp++; if (txi.tx_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b required 1", txi.tx_ready); end
        n_cmp++; if (ps2_clk_oe !== 1'b0) begin n_bad++; $display("FAIL reset_clk_oe: got %b required 0", ps2_clk_oe); end
        n_cmp++; if (ps2_din_oe !== 1'b0) begin n_bad++; $display("FAIL reset_din_oe: got %b required 0", ps2_din_oe); end
        n_cmp++; if ({txi.tx_done, txi.tx_err} !== 2'b00) begin n_bad++; $display("FAIL reset_pulses: got %b required 00", {txi.tx_done, txi.tx_err}); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk25);
        $display("reset: ready=%b clk_oe=%b din_oe=%b", txi.tx_ready, ps2_clk_oe, ps2_din_oe);
    endtask

    task automatic test_frame(input logic [7:0] b, input bit nack);
        int d0, e0, il, cyc;
        logic lo;
        logic [10:0] bits, exp;
        d0 = done_cnt; e0 = err_cnt;
        send(b, 1'b0);
        dev_run(11, nack, 1'b0, bits, il, lo);
        exp = exp_q.pop_front();
        wait_pulse(d0, e0, cyc);
        $display("frame %h nack=%b: bits=%b inhibit=%0d done=%0d err=%0d", b, nack, bits, il, done_cnt - d0, err_cnt - e0);
        n_cmp++; if (il != INH) begin n_bad++; $display("FAIL inhibit_len %h: got %0d required %0d", b, il, INH); end
        n_cmp++; if (lo !== 1'b1) begin n_bad++; $display("FAIL inhibit_last_din_oe %h: got %b required 1", b, lo); end
        n_cmp++; if (bits !== exp) begin n_bad++; $display("FAIL frame_bits %h: got %b required %b", b, bits, exp); end
        n_cmp++; if (done_cnt - d0 != (nack ? 0 : 1)) begin n_bad++; $display("FAIL done_count %h: got %0d required %0d", b, done_cnt - d0, nack ? 0 : 1); end
        n_cmp++; if (err_cnt - e0 != (nack ? 1 : 0)) begin n_bad++; $display("FAIL err_count %h: got %0d required %0d", b, err_cnt - e0, nack ? 1 : 0); end
        @(negedge clk25);
        n_cmp++; if (txi.tx_ready !== 1'b1) begin n_bad++; $display("FAIL ready_after %h: got %b required 1", b, txi.tx_ready); end
    endtask

    task automatic test_timeout();
        int d0, e0, il, c;
        logic lo;
        logic [10:0] bits, exp;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hAA, 1'b0);
        dev_run(0, 1'b0, 1'b0, bits, il, lo);
        exp = exp_q.pop_front();
        c = 0;
        while (txi.tx_err !== 1'b1 && c < TMO + 50) begin @(negedge clk25); c++; end
        $display("timeout: err after %0d cycles clk_oe=%b din_oe=%b", c, ps2_clk_oe, ps2_din_oe);
        n_cmp++; if (c != TMO) begin n_bad++; $display("FAIL timeout_cycles: got %0d required %0d", c, TMO); end
        n_cmp++; if ({ps2_clk_oe, ps2_din_oe} !== 2'b00) begin n_bad++; $display("FAIL timeout_oe: got %b required 00", {ps2_clk_oe, ps2_din_oe}); end
        n_cmp++; if (done_cnt != d0) begin n_bad++; $display("FAIL timeout_done: got %0d required %0d", done_cnt, d0); end
        repeat (3) @(negedge clk25);
        n_cmp++; if (err_cnt - e0 != 1) begin n_bad++; $display("FAIL timeout_err_count: got %0d required 1", err_cnt - e0); end
    endtask

    task automatic test_reset_abort();
        int d0, e0, il;
        logic lo;
        logic [10:0] bits, exp;
        d0 = done_cnt; e0 = err_cnt;
        send(8'hA5, 1'b0);
        dev_run(4, 1'b0, 1'b0, bits, il, lo);
        exp = exp_q.pop_front();
        n_cmp++; if (ps2_din_oe !== 1'b1) begin n_bad++; $display("FAIL abort_pre_din_oe: got %b required 1", ps2_din_oe); end
        #5 rst_n = 1'b0;
        #1;
        $display("abort: clk_oe=%b din_oe=%b during reset", ps2_clk_oe, ps2_din_oe);
        n_cmp++; if ({ps2_clk_oe, ps2_din_oe} !== 2'b00) begin n_bad++; $display("FAIL abort_async_oe: got %b required 00", {ps2_clk_oe, ps2_din_oe}); end
        @(negedge clk25);
        rst_n = 1'b1;
        repeat (50) @(negedge clk25);
        n_cmp++; if (done_cnt != d0 || err_cnt != e0) begin n_bad++; $display("FAIL abort_no_pulse: done+%0d err+%0d required 0", done_cnt - d0, err_cnt - e0); end
        test_frame(8'hF4, 1'b0);
    endtask

    task automatic test_back_to_back();
        int d0, e0, il, cyc, extra;
        logic lo;
        logic [10:0] bits, exp;
        d0 = done_cnt; e0 = err_cnt;
        send(8'h3C, 1'b1);
        dev_run(11, 1'b0, GLITCH, bits, il, lo);
        exp = exp_q.pop_front();
        wait_pulse(d0, e0, cyc);
        txi.tx_valid = 1'b0;
        extra = 0;
        repeat (80) begin
            @(negedge clk25);
            if (ps2_clk_oe === 1'b1) extra++;
        end
        $display("hold 3c glitch=%b: bits=%b done=%0d err=%0d extra_inhibit=%0d", GLITCH, bits, done_cnt - d0, err_cnt - e0, extra);
        n_cmp++; if (bits !== exp) begin n_bad++; $display("FAIL hold_bits: got %b required %b", bits, exp); end
        n_cmp++; if (done_cnt - d0 != 1 || err_cnt != e0) begin n_bad++; $display("FAIL hold_pulses: done+%0d err+%0d required 1/0", done_cnt - d0, err_cnt - e0); end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL hold_single_frame: extra inhibit cycles %0d required 0", extra); end
    endtask

    initial begin
        txi.tx_valid = 1'b0;
        txi.tx_data  = 8'h00;
        test_reset();
        test_frame(8'hFF, 1'b0);
        test_frame(8'hED, 1'b0);
        test_frame(8'h55, 1'b1);
        test_timeout();
        test_reset_abort();
        test_back_to_back();
        n_cmp++; if (both_cnt != 0) begin n_bad++; $display("FAIL done_err_overlap: got %0d required 0", both_cnt); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
